// File: rtl/uart_alu_if.sv
// uart_alu_if: collects A, B and opcode bytes from a UART, runs the ALU and sends the result back.
module uart_alu_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_err
);
    localparam int NB_CNT = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
    state_t state, state_next;
    logic [NB_CNT-1:0] cnt, cnt_next;
    logic err_next;
    logic timed;
    logic expired;
    logic op_ok;
    assign timed   = state == WAIT_B || state == WAIT_OP;
    assign expired = timed && cnt == NB_CNT'(TIMEOUT - 1);
    assign op_ok   = i_rx_data[NB_DATA-1:NB_OP] == '0;
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            WAIT_A:  state_next = i_rx_done ? WAIT_B : WAIT_A;
            WAIT_B: begin
                state_next = i_rx_done ? WAIT_OP : expired ? WAIT_A : WAIT_B;
                err_next   = !i_rx_done && expired;
            end
            WAIT_OP: begin
                state_next = i_rx_done ? (op_ok ? EXEC : WAIT_A) : expired ? WAIT_A : WAIT_OP;
                err_next   = i_rx_done ? !op_ok : expired;
            end
            EXEC: begin
                state_next = SEND;
                err_next   = i_rx_done;
            end
            SEND: begin
                state_next = WAIT_TX;
                err_next   = i_rx_done;
            end
            WAIT_TX: begin
                state_next = i_tx_done ? WAIT_A : WAIT_TX;
                err_next   = i_rx_done;
            end
            default: state_next = WAIT_A;
        endcase
        // Counter saturates implicitly: reaching TIMEOUT-1 always forces a state change.
        cnt_next = (state_next != state || i_rx_done) ? '0 : timed ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= WAIT_A;
            cnt        <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            o_err      <= err_next;
            o_tx_start <= state_next == SEND;
            if (state == WAIT_A && i_rx_done)
                o_alu_a <= i_rx_data;
            if (state == WAIT_B && i_rx_done)
                o_alu_b <= i_rx_data;
            if (state == WAIT_OP && i_rx_done && op_ok)
                o_alu_op <= i_rx_data[NB_OP-1:0];
            if (state == EXEC)
                o_tx_data <= i_alu_result;
        end
    end
endmodule

// File: doc/uart_alu_if.md
UART_ALU_IF -- requirements
Module: uart_alu_if

Interface
REQ-001 Parameter NB_DATA, default 8: width of UART bytes and ALU operands/result.
REQ-002 Parameter NB_OP, default 6: ALU opcode width, taken from the low bits of the opcode byte.
REQ-003 Parameter TIMEOUT, default 1_000_000: maximum idle clock cycles allowed between bytes of one command.
REQ-004 The port list SHALL be as follows, with no others:
- i_clk, in, 1: single clock.
- i_rst, in, 1: reset, synchronous and active-high.
- i_rx_data, in, NB_DATA: received byte from the UART receiver.
- i_rx_done, in, 1: one-cycle pulse marking i_rx_data valid.
- i_tx_done, in, 1: one-cycle pulse when the UART transmitter has finished a byte.
- i_alu_result, in, NB_DATA: combinational result from the ALU.
- o_alu_a, out, NB_DATA: registered operand A.
- o_alu_b, out, NB_DATA: registered operand B.
- o_alu_op, out, NB_OP: registered opcode.
- o_tx_data, out, NB_DATA: byte to transmit.
- o_tx_start, out, 1: one-cycle transmit request.
- o_err, out, 1: one-cycle error pulse.

Function
REQ-005 The FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX.
REQ-006 In WAIT_A, i_rx_done=1 SHALL load o_alu_a<=i_rx_data and move to WAIT_B.
REQ-007 In WAIT_B, i_rx_done=1 SHALL load o_alu_b<=i_rx_data and move to WAIT_OP.
REQ-008 In WAIT_OP, i_rx_done=1 with i_rx_data[NB_DATA-1:NB_OP]==0 SHALL load o_alu_op<=i_rx_data[NB_OP-1:0] and move to EXEC.
REQ-009 In WAIT_OP, i_rx_done=1 with nonzero upper bits SHALL pulse o_err for 1 cycle, leave o_alu_op unchanged, and return to WAIT_A (command discarded).
REQ-010 EXEC SHALL last exactly 1 cycle, load o_tx_data<=i_alu_result, and move to SEND.
REQ-011 SEND SHALL last exactly 1 cycle; o_tx_start SHALL be 1 during that cycle only, and the state moves to WAIT_TX.
REQ-012 In WAIT_TX, i_tx_done=1 SHALL move the FSM to WAIT_A.
REQ-013 Latency: with the opcode byte's i_rx_done at cycle N, o_tx_start SHALL be high at cycle N+2, with o_tx_data equal to the ALU result of the latched A/B/op.
REQ-014 o_alu_a, o_alu_b and o_alu_op SHALL hold their values until overwritten by a later command.
REQ-015 i_rx_done in EXEC, SEND or WAIT_TX SHALL be ignored for data and SHALL pulse o_err for 1 cycle (overrun).
REQ-016 A timeout counter SHALL clear on every state change and on every i_rx_done.
REQ-017 The timeout counter SHALL increment only in WAIT_B and WAIT_OP.
REQ-018 When the counter reaches TIMEOUT-1 in WAIT_B or WAIT_OP, the FSM SHALL pulse o_err and return to WAIT_A; operand registers are unchanged.
REQ-019 WAIT_A and WAIT_TX SHALL have no timeout.
REQ-020 The counter width SHALL be clog2(TIMEOUT) and it SHALL never wrap.
REQ-021 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-022 i_rx_done coinciding with timeout expiry SHALL take priority: the byte is accepted and the counter cleared.
REQ-023 o_err SHALL be registered and never high for 2 consecutive cycles from a single event.

Reset
REQ-024 While i_rst=1 at a rising i_clk edge, the state SHALL become WAIT_A and the timeout counter 0.
REQ-025 Reset SHALL force o_alu_a=0, o_alu_b=0, o_alu_op=0, o_tx_data=0, o_tx_start=0 and o_err=0.
REQ-026 Reset mid-command or mid-transmission SHALL discard partial bytes; the first i_rx_done after reset release is operand A.
REQ-027 i_rx_done during reset SHALL be ignored.

Verification
REQ-028 Bytes 0x03, 0x0C, 0x20 with i_alu_result=0x0F -> o_alu_a=0x03, o_alu_b=0x0C, o_alu_op=6'b100000; o_tx_start at N+2 with o_tx_data=0x0F.
REQ-029 After i_tx_done, bytes 0x08, 0x02, 0x02 with i_alu_result=0x02 -> o_alu_op=6'b000010, o_tx_data=0x02; a second clean command completes.
REQ-030 Opcode byte 0xC0 -> o_err 1-cycle pulse, no o_tx_start; next bytes 0x01, 0x01, 0x20 complete normally.
REQ-031 Byte 0x05, then no traffic for TIMEOUT cycles (TIMEOUT=16 in bench) -> o_err at cycle 16 of WAIT_B; the next byte loads o_alu_a.
REQ-032 Byte on i_rx_done during WAIT_TX -> o_err pulse, o_tx_data unchanged, state still WAIT_TX until i_tx_done.
REQ-033 i_rst asserted in WAIT_OP after A=0x11 and B=0x22 -> all outputs 0; the next three bytes form a fresh command.
